mmap_bram_arbiter: RTL and testbench
====================================

MMAP_BRAM_ARBITER -- requirements
Module: mmap_bram_arbiter

Interface
REQ-001 Parameters: ADDR_W default 32, BRAM address width; DATA_W default 64, BRAM data width; RD_LAT default 1, BRAM read latency in cycles (1..3); LOCK_MAX default 16, maximum consecutive locked grants.
REQ-002 clk  in  1  single clock; all logic on posedge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 mN_req  in  1  access request, N=0,1.
REQ-005 mN_we  in  1  1 = write, 0 = read.
REQ-006 mN_lock  in  1  hold grant for back-to-back accesses.
REQ-007 mN_addr  in  ADDR_W  byte address.
REQ-008 mN_wdata  in  DATA_W  write data.
REQ-009 mN_gnt  out  1  request accepted this cycle.
REQ-010 mN_rvalid  out  1  m_rdata valid for requester N.
REQ-011 m_rdata  out  DATA_W  shared read-return data.
REQ-012 clkb  out  1  equals clk.
REQ-013 enb  out  1  BRAM enable.
REQ-014 web  out  DATA_W/8  byte write enables.
REQ-015 addrb  out  ADDR_W  BRAM address.
REQ-016 dinb  out  DATA_W  BRAM write data.
REQ-017 doutb  in  DATA_W  BRAM read data.
REQ-018 frame_done  in  1  one-cycle pulse per completed frame.
REQ-019 msi_enable  in  1  interrupt generation enable.
REQ-020 usr_irq_req  out  1  interrupt request to the DMA core.
REQ-021 usr_irq_ack  in  1  interrupt acknowledge pulse.
REQ-022 irq_ovf  out  1  sticky pending-counter overflow flag.

Function
REQ-023 Arbitration SHALL issue at most one access per cycle; mN_gnt is combinational from the requests and arbiter state in the same cycle.
REQ-024 Single requester active: that requester is granted every cycle it requests; no idle cycles are inserted.
REQ-025 Both requesting and no lock active: round-robin, i.e. the requester not granted last wins; pointer after reset = m1, so m0 wins the first tie.
REQ-026 Lock: while the last-granted requester holds mN_lock and mN_req, it keeps the grant for up to LOCK_MAX consecutive grants.
REQ-027 At LOCK_MAX, if the other requester is requesting, the grant SHALL switch for at least one cycle; the lock counter resets on any switch or on lock deassert.
REQ-028 The BRAM outputs are registered: for a grant in cycle N, cycle N+1 carries enb=1, addrb=granted addr, dinb=granted wdata, web=all-ones on write and 0 on read.
REQ-029 No grant in cycle N: cycle N+1 carries enb=0 and web=0; addrb and dinb hold their previous values.
REQ-030 Read return: a read granted in cycle N asserts mN_rvalid for exactly one cycle, at cycle N+1+RD_LAT, with m_rdata=doutb.
REQ-031 Read return is tracked by a RD_LAT-deep requester-ID pipeline; back-to-back reads from either requester return in grant order with no loss.
REQ-032 Writes SHALL produce no rvalid.
REQ-033 IRQ pending counter: 4 bits; +1 on frame_done; -1 on an accepted ack.
REQ-034 frame_done and an accepted ack in the same cycle: counter unchanged.
REQ-035 frame_done with counter=15 (and no same-cycle ack): counter stays 15 and irq_ovf is set.
REQ-036 IRQ FSM states: IDLE, REQ, GAP.
REQ-037 IDLE->REQ when pending>0 and msi_enable=1.
REQ-038 REQ->GAP on usr_irq_ack; this ack is the accepted ack that decrements pending.
REQ-039 GAP->IDLE unconditionally after one cycle.
REQ-040 usr_irq_req SHALL be 1 only in REQ (registered output).
REQ-041 Deasserting msi_enable while in REQ does not drop usr_irq_req; usr_irq_ack outside REQ is ignored.

Reset
REQ-042 While reset=1, on each clock edge: enb=0, web=0, addrb=0, dinb=0, mN_rvalid=0, usr_irq_req=0, irq_ovf=0, pending=0, IRQ FSM=IDLE, RR pointer=m1, lock counter=0.
REQ-043 mN_gnt SHALL be 0 while reset=1.
REQ-044 Reads in flight when reset asserts are discarded: no rvalid after reset releases.

Verification
REQ-045 m0 writes addr 0x0,0x8,0x10 on consecutive cycles, m1 idle -> three gnts; enb=1 and web=0xFF for three consecutive cycles one cycle later; addrb 0x0,0x8,0x10.
REQ-046 m0 and m1 both request continuously, no lock -> gnt sequence m0,m1,m0,m1; BRAM addrb alternates accordingly.
REQ-047 m0 locked read stream with m1 requesting, LOCK_MAX=16 -> 16 m0 grants, one m1 grant, then m0 resumes; each m0 rvalid arrives 2 cycles after its gnt (RD_LAT=1).
REQ-048 Three frame_done pulses, msi_enable=1, ack each request 3 cycles after usr_irq_req rises -> three usr_irq_req assertions, each followed by at least one low cycle; pending ends at 0.
REQ-049 17 frame_done pulses with msi_enable=0 -> pending=15, irq_ovf=1, usr_irq_req=0.
REQ-050 Raise msi_enable -> 15 requests on acks; irq_ovf stays 1 until reset.
REQ-051 Assert reset one cycle after a read gnt -> no rvalid appears; all outputs hold reset values.

Source files
------------

// File: rtl/mmap_bram_arbiter.sv
// Two-master arbiter in front of a single-port BRAM, with read-return routing
// and a frame-completion interrupt requester with a 4-bit pending counter.
module mmap_bram_arbiter #(
  parameter int          ADDR_W   = 32,
  parameter int          DATA_W   = 64,
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned LOCK_MAX = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                m0_req,
  input  logic                m0_we,
  input  logic                m0_lock,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  output logic                m0_gnt,
  output logic                m0_rvalid,
  input  logic                m1_req,
  input  logic                m1_we,
  input  logic                m1_lock,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  output logic                m1_gnt,
  output logic                m1_rvalid,
  output logic [DATA_W-1:0]   m_rdata,
  output logic                clkb,
  output logic                enb,
  output logic [DATA_W/8-1:0] web,
  output logic [ADDR_W-1:0]   addrb,
  output logic [DATA_W-1:0]   dinb,
  input  logic [DATA_W-1:0]   doutb,
  input  logic                frame_done,
  input  logic                msi_enable,
  output logic                usr_irq_req,
  input  logic                usr_irq_ack,
  output logic                irq_ovf
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);
  localparam logic [CNT_W-1:0] LOCK_TOP = CNT_W'(LOCK_MAX);

  typedef enum logic [1:0] {IDLE, REQ, GAP} irq_state_t;

  logic              last;      // 0 = m0 granted last, 1 = m1
  logic [CNT_W-1:0]  lock_cnt;
  logic              g0, g1, hold, g_we, g_lock;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_data;
  logic [RD_LAT:0]   rd_v, rd_id;
  irq_state_t        state;
  logic [3:0]        pending;
  logic              ack_ok;

  assign clkb    = clk;
  assign m_rdata = doutb;
  assign m0_gnt  = g0;
  assign m1_gnt  = g1;

  always_comb begin
    hold = (last ? m1_lock : m0_lock) && (lock_cnt < LOCK_TOP);
    g0   = 1'b0;
    g1   = 1'b0;
    if (!reset) begin
      if (m0_req && m1_req) begin
        // a held lock keeps the previous winner, otherwise the other side wins
        g1 = hold ? last : !last;
        g0 = !g1;
      end else begin
        g0 = m0_req;
        g1 = m1_req;
      end
    end
    g_we   = g1 ? m1_we    : m0_we;
    g_lock = g1 ? m1_lock  : m0_lock;
    g_addr = g1 ? m1_addr  : m0_addr;
    g_data = g1 ? m1_wdata : m0_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last     <= 1'b1;
      lock_cnt <= '0;
      enb      <= 1'b0;
      web      <= '0;
      addrb    <= '0;
      dinb     <= '0;
      rd_v     <= '0;
      rd_id    <= '0;
    end else begin
      enb   <= g0 | g1;
      rd_v  <= {rd_v[RD_LAT-1:0], (g0 | g1) & ~g_we};
      rd_id <= {rd_id[RD_LAT-1:0], g1};
      if (g0 || g1) begin
        web   <= {(DATA_W/8){g_we}};
        addrb <= g_addr;
        dinb  <= g_data;
        last  <= g1;
        // lock_cnt counts consecutive locked grants to the current owner
        if (g1 != last)
          lock_cnt <= g_lock ? CNT_W'(1) : '0;
        else if (!g_lock)
          lock_cnt <= '0;
        else if (lock_cnt != LOCK_TOP)
          lock_cnt <= lock_cnt + CNT_W'(1);
      end else begin
        web <= '0;
        if (!(last ? m1_lock : m0_lock))
          lock_cnt <= '0;
      end
    end
  end

  assign m0_rvalid = rd_v[RD_LAT] & ~rd_id[RD_LAT];
  assign m1_rvalid = rd_v[RD_LAT] &  rd_id[RD_LAT];

  assign ack_ok = (state == REQ) && usr_irq_ack;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      usr_irq_req <= 1'b0;
      pending     <= '0;
      irq_ovf     <= 1'b0;
    end else begin
      case ({frame_done, ack_ok})
        2'b10: begin
          if (pending == 4'hF) irq_ovf <= 1'b1;
          else                 pending <= pending + 4'd1;
        end
        2'b01:   pending <= pending - 4'd1;
        default: ;
      endcase
      case (state)
        IDLE: if (pending != '0 && msi_enable) begin
          state       <= REQ;
          usr_irq_req <= 1'b1;
        end
        REQ: if (usr_irq_ack) begin
          state       <= GAP;
          usr_irq_req <= 1'b0;
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmap_bram_arbiter.sv
// Scoreboard bench for mmap_bram_arbiter: stimulus pushes expected grants, BRAM
// accesses and read returns; negedge monitors pop and compare.
module tb_mmap_bram_arbiter;
  localparam int AW = 32;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          m0_req = 0, m0_we = 0, m0_lock = 0;
  logic          m1_req = 0, m1_we = 0, m1_lock = 0;
  logic [AW-1:0] m0_addr = '0, m1_addr = '0;
  logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
  logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [DW-1:0] m_rdata, dinb;
  logic [DW-1:0] doutb = '0;
  logic          clkb, enb;
  logic [DW/8-1:0] web;
  logic [AW-1:0] addrb;
  logic          frame_done = 0, msi_enable = 0, usr_irq_ack = 0;
  logic          usr_irq_req, irq_ovf;

  mmap_bram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .LOCK_MAX(16)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
    .m_rdata(m_rdata), .clkb(clkb), .enb(enb), .web(web), .addrb(addrb),
    .dinb(dinb), .doutb(doutb), .frame_done(frame_done), .msi_enable(msi_enable),
    .usr_irq_req(usr_irq_req), .usr_irq_ack(usr_irq_ack), .irq_ovf(irq_ovf)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] din; logic [7:0] web; } bram_t;
  typedef struct { int id; logic [DW-1:0] data; int at; } rd_t;
  int    gq[$];
  bram_t bq[$];
  rd_t   rq[$];

  function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
    return {~a, a};
  endfunction

  // BRAM model with one cycle of read latency
  always @(posedge clk) if (enb === 1'b1) doutb <= mem_f(addrb);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  int    mon_g;
  bram_t mon_b;
  rd_t   mon_r;
  always @(negedge clk) begin
    if ((m0_gnt | m1_gnt) === 1'b1) begin
      if (gq.size() == 0) check("gnt_extra", {m1_gnt, m0_gnt}, 0);
      else begin
        mon_g = gq.pop_front();
        check("gnt", {m1_gnt, m0_gnt}, (mon_g == 1) ? 2 : 1);
      end
    end
    if (enb === 1'b1) begin
      if (bq.size() == 0) check("enb_extra", enb, 0);
      else begin
        mon_b = bq.pop_front();
        check("addrb", addrb, mon_b.addr);
        check("dinb", dinb, mon_b.din);
        check("web", web, mon_b.web);
      end
    end
    if ((m0_rvalid | m1_rvalid) === 1'b1) begin
      if (rq.size() == 0) check("rvalid_extra", {m1_rvalid, m0_rvalid}, 0);
      else begin
        mon_r = rq.pop_front();
        check("rvalid_id", {m1_rvalid, m0_rvalid}, (mon_r.id == 1) ? 2 : 1);
        check("rdata", m_rdata, mon_r.data);
        check("rvalid_cycle", cyc, mon_r.at);
      end
    end
  end

  // drive one cycle of requests; eg = expected winner (-1 none)
  task automatic issue(input logic r0, w0, l0, input logic [AW-1:0] a0,
                       input logic r1, w1, l1, input logic [AW-1:0] a1, input int eg);
    bram_t b;
    rd_t   r;
    @(posedge clk); #1;
    m0_req = r0; m0_we = w0; m0_lock = l0; m0_addr = a0; m0_wdata = {32'h1111_0000, a0};
    m1_req = r1; m1_we = w1; m1_lock = l1; m1_addr = a1; m1_wdata = {32'h2222_0000, a1};
    if (eg >= 0) begin
      b.addr = (eg == 1) ? a1 : a0;
      b.din  = (eg == 1) ? m1_wdata : m0_wdata;
      b.web  = (((eg == 1) ? w1 : w0) == 1'b1) ? 8'hFF : 8'h00;
      gq.push_back(eg);
      bq.push_back(b);
      if (b.web == 8'h00) begin
        r.id = eg; r.data = mem_f(b.addr); r.at = cyc + 2;
        rq.push_back(r);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) issue(0, 0, 0, '0, 0, 0, 0, '0, -1);
  endtask

  task automatic pulse_fd();
    @(posedge clk); #1 frame_done = 1;
    @(posedge clk); #1 frame_done = 0;
  endtask

  // service one interrupt: wait for usr_irq_req, ack dly cycles later
  task automatic service(input int dly);
    bit ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (usr_irq_req === 1'b1) ok = 1;
    end
    check("irq_req_rise", ok, 1);
    repeat (dly) @(posedge clk);
    #1 usr_irq_ack = 1;
    @(posedge clk); #1 usr_irq_ack = 0;
    @(negedge clk);
    check("irq_req_drop", usr_irq_req, 0);
  endtask

  task automatic quiet_irq(input int n);
    bit seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (usr_irq_req !== 1'b0) seen = 1;
    end
    check("irq_quiet", seen, 0);
  endtask

  task automatic check_reset_outs();
    check("rst_enb", enb, 0);
    check("rst_web", web, 0);
    check("rst_addrb", addrb, 0);
    check("rst_dinb", dinb, 0);
    check("rst_rvalid", {m1_rvalid, m0_rvalid}, 0);
    check("rst_irq_req", usr_irq_req, 0);
    check("rst_irq_ovf", irq_ovf, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int k;
    // reset with requests pending: no grant, outputs at reset values
    m0_req = 1; m1_req = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_gnt", {m1_gnt, m0_gnt}, 0);
    check_reset_outs();
    @(posedge clk); #1 reset = 0; m0_req = 0; m1_req = 0;

    // both requesting, no lock: m0 wins the first tie then alternation
    issue(1, 0, 0, 32'h20, 1, 0, 0, 32'h40, 0);
    issue(1, 0, 0, 32'h20, 1, 0, 0, 32'h40, 1);
    issue(1, 0, 0, 32'h20, 1, 0, 0, 32'h40, 0);
    issue(1, 0, 0, 32'h20, 1, 0, 0, 32'h40, 1);
    idle(1);

    // single requester writes back-to-back
    issue(1, 1, 0, 32'h0,  0, 0, 0, '0, 0);
    issue(1, 1, 0, 32'h8,  0, 0, 0, '0, 0);
    issue(1, 1, 0, 32'h10, 0, 0, 0, '0, 0);
    idle(2);

    // locked m0 read stream vs m1: 16 m0, one m1, then m0 resumes
    k = 0;
    for (int i = 0; i < 19; i++) begin
      if (i == 16) issue(1, 0, 1, 32'h200 + 8 * k, 1, 0, 0, 32'h300, 1);
      else begin
        issue(1, 0, 1, 32'h200 + 8 * k, (i < 16) ? 1'b1 : 1'b0, 0, 0, 32'h300, 0);
        k++;
      end
    end
    idle(4);

    // three frames serviced with a 3-cycle ack delay
    msi_enable = 1;
    repeat (3) pulse_fd();
    repeat (3) service(3);
    #1 usr_irq_ack = 1;
    @(posedge clk); #1 usr_irq_ack = 0;
    quiet_irq(10);
    check("irq_ovf_3", irq_ovf, 0);

    // overflow of the pending counter with interrupts disabled
    msi_enable = 0;
    repeat (15) pulse_fd();
    @(negedge clk);
    check("irq_ovf_15", irq_ovf, 0);
    repeat (2) pulse_fd();
    @(negedge clk);
    check("irq_ovf_17", irq_ovf, 1);
    check("irq_req_off", usr_irq_req, 0);

    // drain the 15 saturated entries
    msi_enable = 1;
    repeat (15) service(0);
    quiet_irq(10);
    check("irq_ovf_sticky", irq_ovf, 1);

    // reset one cycle after a read grant: the read never returns
    issue(1, 0, 0, 32'h80, 0, 0, 0, '0, 0);
    void'(rq.pop_back());
    @(posedge clk); #1 reset = 1; m0_req = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outs();
    @(posedge clk); #1 reset = 0;
    idle(6);

    check("gq_left", gq.size(), 0);
    check("bq_left", bq.size(), 0);
    check("rq_left", rq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
